sssp_update_packer: RTL and testbench

- Sits directly downstream of the N_LANES per-lane SSSP edge-relax pipelines.
- Each cycle it accepts up to N_LANES 64-bit relaxed-distance updates, laid out as {weight[31:0], dst[31:0]}.
- It compacts the valid updates in lane order and packs them 8 per 512-bit cache line.
- Lines are buffered in an output FIFO for the write-back channel. A padded partial line is flushed at end of input, and completion is signalled.

---
 rtl/graph_pkg.sv | 20 ++
 rtl/sssp_line_fifo.sv | 51 +++++
 rtl/sssp_update_packer.sv | 170 +++++++++++++++++
 tb/tb_sssp_update_packer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// Shared types and constants for the SSSP write-back path.
package graph_pkg;

    localparam int          CL_WORDS  = 8;
    localparam logic [1:0]  CTRL_EDGE = 2'h2;
    localparam logic [63:0] PAD_WORD  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [31:0] weight;
        logic [31:0] dst;
    } update_t;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_ACTIVE,
        PK_FLUSH,
        PK_DRAIN
    } pack_state_t;

endpackage

// File: rtl/sssp_line_fifo.sv
// Show-ahead line FIFO; rd_data is the head entry and reads as zero when empty.
module sssp_line_fifo import graph_pkg::*; #(
    parameter int WIDTH = 64 * CL_WORDS,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sssp_update_packer.sv
// Compacts per-lane relaxed-distance updates into 512-bit lines for write-back.
//   state     | meaning
//   PK_IDLE   | waiting for the edge-processing phase to start
//   PK_ACTIVE | packing lane updates into lines
//   PK_FLUSH  | pushing the padded partial line, if any
//   PK_DRAIN  | waiting for the FIFO to empty, then pulsing done
module sssp_update_packer #(
    parameter int          N_LANES    = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [63:0] PAD_WORD   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [64*N_LANES-1:0]  upd_word,
    input  logic [N_LANES-1:0]     upd_valid,
    input  logic [1:0]             control_in,
    input  logic                   last_input_in,
    output logic [511:0]           line_data,
    output logic                   line_valid,
    input  logic                   line_ready,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   done,
    output logic [31:0]            update_count,
    output logic [31:0]            line_count
);

    import graph_pkg::*;

    localparam int TOT   = CL_WORDS + N_LANES;
    localparam int IW    = $clog2(TOT);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pack_state_t      state, state_nxt;
    update_t          acc       [CL_WORDS];
    update_t          acc_nxt   [CL_WORDS];
    update_t          acc_after [CL_WORDS];
    update_t          words     [TOT];
    logic [2:0]       acc_cnt, acc_cnt_nxt;
    logic [IW-1:0]    idx;
    logic [3:0]       pop_cnt;
    logic [4:0]       total;
    logic             fill;
    logic [511:0]     pack_line;
    logic [511:0]     pad_line;
    logic [511:0]     push_data;
    logic             push, pop, drop, accept, entry;
    logic             full, empty;
    logic [CNT_W-1:0] fifo_count;

    // Pending words first, then valid lanes in ascending order.
    always_comb begin
        words     = '{default: '0};
        acc_after = '{default: '0};
        pack_line = '0;
        pad_line  = '0;
        pop_cnt   = '0;
        idx       = IW'(acc_cnt);
        for (int k = 0; k < CL_WORDS; k++) begin
            if (k < int'(acc_cnt)) words[k] = acc[k];
        end
        for (int i = 0; i < N_LANES; i++) begin
            if (upd_valid[i]) begin
                words[idx] = upd_word[64*i +: 64];
                idx        = idx + IW'(1);
                pop_cnt    = pop_cnt + 4'd1;
            end
        end
        total = 5'(acc_cnt) + 5'(pop_cnt);
        fill  = (total >= 5'(CL_WORDS));
        for (int k = 0; k < CL_WORDS; k++) begin
            pack_line[64*k +: 64] = words[k];
            pad_line[64*k +: 64]  = (k < int'(acc_cnt)) ? acc[k] : PAD_WORD;
        end
        for (int k = 0; k < N_LANES; k++) begin
            acc_after[k] = words[k + CL_WORDS];
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        acc_cnt_nxt = acc_cnt;
        push        = 1'b0;
        push_data   = pack_line;
        entry       = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        case (state)
            PK_IDLE: begin
                if (control_in == CTRL_EDGE) begin
                    entry     = 1'b1;
                    accept    = 1'b1;
                    state_nxt = last_input_in ? PK_FLUSH : PK_ACTIVE;
                end
            end
            PK_ACTIVE: begin
                accept = 1'b1;
                if (last_input_in) state_nxt = PK_FLUSH;
            end
            PK_FLUSH: begin
                if (acc_cnt == 3'd0) begin
                    state_nxt = PK_DRAIN;
                end else if (!full) begin
                    push        = 1'b1;
                    push_data   = pad_line;
                    acc_cnt_nxt = 3'd0;
                    state_nxt   = PK_DRAIN;
                end
            end
            PK_DRAIN: begin
                if (empty) begin
                    done      = 1'b1;
                    state_nxt = PK_IDLE;
                end
            end
            default: state_nxt = PK_IDLE;
        endcase
        if (accept) begin
            if (fill) begin
                push        = 1'b1;
                acc_nxt     = acc_after;
                acc_cnt_nxt = 3'(total - 5'(CL_WORDS));
            end else begin
                for (int k = 0; k < CL_WORDS; k++) acc_nxt[k] = words[k];
                acc_cnt_nxt = total[2:0];
            end
        end
    end

    assign pop         = line_ready && !empty;
    assign line_valid  = !empty;
    assign drop        = push && full && !pop;
    assign almost_full = (fifo_count >= CNT_W'(FIFO_DEPTH - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PK_IDLE;
            acc          <= '{default: '0};
            acc_cnt      <= 3'd0;
            update_count <= '0;
            line_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            acc_cnt  <= acc_cnt_nxt;
            overflow <= (entry ? 1'b0 : overflow) | drop;
            line_count <= (entry ? 32'd0 : line_count) + 32'(push);
            if (accept)
                update_count <= (entry ? 32'd0 : update_count) + 32'(pop_cnt);
        end
    end

    sssp_line_fifo #(
        .WIDTH (512),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (line_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sssp_update_packer.sv
// Directed bench for sssp_update_packer: packing, padding, overflow, reset.
module tb_sssp_update_packer;

    localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] upd_word = '0;
    logic [3:0]   upd_valid = '0;
    logic [1:0]   control_in = '0;
    logic         last_input_in = 1'b0;
    logic         line_ready = 1'b0;
    logic [511:0] line_data;
    logic         line_valid;
    logic         almost_full;
    logic         overflow;
    logic         done;
    logic [31:0]  update_count;
    logic [31:0]  line_count;

    int checks = 0;
    int failures = 0;

    sssp_update_packer #(
        .N_LANES    (4),
        .FIFO_DEPTH (8),
        .PAD_WORD   (PAD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .upd_word      (upd_word),
        .upd_valid     (upd_valid),
        .control_in    (control_in),
        .last_input_in (last_input_in),
        .line_data     (line_data),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .done          (done),
        .update_count  (update_count),
        .line_count    (line_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        upd_word      = '0;
        upd_valid     = '0;
        control_in    = 2'h0;
        last_input_in = 1'b0;
    endtask

    // lane i carries base+i
    task automatic beat(input logic [3:0] v, input logic [63:0] base,
                        input logic [1:0] ctrl, input logic last);
        for (int i = 0; i < 4; i++) upd_word[64*i +: 64] = base + 64'(i);
        upd_valid     = v;
        control_in    = ctrl;
        last_input_in = last;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({line_valid, almost_full, overflow, done} !== 4'b0 || line_data !== '0
            || update_count !== 32'd0 || line_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b af=%b ovf=%b done=%b uc=%0d lc=%0d, all required 0",
                     line_valid, almost_full, overflow, done, update_count, line_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_line();
        logic [511:0] exp_line;
        int cyc;
        line_ready = 1'b1;
        beat(4'hF, 64'h1, 2'h2, 1'b0);
        step();
        checks++;
        if (line_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_line_early_valid: got %b required 0", line_valid);
        end
        beat(4'hF, 64'h5, 2'h0, 1'b0);
        step();
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = 64'(k + 1);
        checks++;
        if (line_valid !== 1'b1 || line_data !== exp_line) begin
            failures++;
            $display("FAIL full_line_data: valid=%b data=%h required %h", line_valid, line_data, exp_line);
        end
        checks++;
        if (update_count !== 32'd8 || line_count !== 32'd1) begin
            failures++;
            $display("FAIL full_line_counts: uc=%0d lc=%0d required 8/1", update_count, line_count);
        end
        idle_inputs();
        last_input_in = 1'b1;
        step();
        last_input_in = 1'b0;
        checks++;
        if (line_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_line_popped: valid=%b required 0", line_valid);
        end
        cyc = 0;
        while (!done && cyc < 6) begin
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL full_line_done: done=%b required 1 within 6 cycles", done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL full_line_done_pulse: done=%b required 0 after one cycle", done);
        end
    endtask

    task automatic test_padded_line();
        logic [63:0]  a = 64'h0000_0007_0000_0011;
        logic [63:0]  b = 64'h0000_0009_0000_0022;
        logic [511:0] exp_line;
        int cyc;
        line_ready = 1'b0;
        upd_word   = {b, 64'hDEAD_0000_0000_0002, a, 64'hDEAD_0000_0000_0000};
        upd_valid  = 4'b1010;
        control_in = 2'h2;
        step();
        checks++;
        if (update_count !== 32'd2 || line_count !== 32'd0) begin
            failures++;
            $display("FAIL padded_counts_cleared: uc=%0d lc=%0d required 2/0", update_count, line_count);
        end
        idle_inputs();
        last_input_in = 1'b1;
        step();
        last_input_in = 1'b0;
        step();
        exp_line = {6{PAD}};
        exp_line = {exp_line[383:0], b, a};
        checks++;
        if (line_valid !== 1'b1 || line_data !== exp_line) begin
            failures++;
            $display("FAIL padded_line_data: valid=%b data=%h required %h", line_valid, line_data, exp_line);
        end
        checks++;
        if (line_count !== 32'd1) begin
            failures++;
            $display("FAIL padded_line_count: got %0d required 1", line_count);
        end
        step();
        step();
        checks++;
        if (done !== 1'b0 || line_valid !== 1'b1) begin
            failures++;
            $display("FAIL padded_done_held: done=%b valid=%b required 0/1", done, line_valid);
        end
        line_ready = 1'b1;
        cyc = 0;
        while (!done && cyc < 6) begin
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || line_valid !== 1'b0) begin
            failures++;
            $display("FAIL padded_done: done=%b valid=%b required 1/0", done, line_valid);
        end
        step();
    endtask

    task automatic test_three_beats();
        logic [511:0] exp_line;
        int cyc;
        line_ready = 1'b1;
        beat(4'hF, 64'h1, 2'h2, 1'b0);
        step();
        beat(4'hF, 64'h5, 2'h0, 1'b0);
        step();
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = 64'(k + 1);
        checks++;
        if (line_valid !== 1'b1 || line_data !== exp_line) begin
            failures++;
            $display("FAIL three_beats_line1: valid=%b data=%h required %h", line_valid, line_data, exp_line);
        end
        beat(4'hF, 64'h9, 2'h0, 1'b1);
        step();
        idle_inputs();
        step();
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = (k < 4) ? 64'(k + 9) : PAD;
        checks++;
        if (line_valid !== 1'b1 || line_data !== exp_line) begin
            failures++;
            $display("FAIL three_beats_line2: valid=%b data=%h required %h", line_valid, line_data, exp_line);
        end
        checks++;
        if (line_count !== 32'd2 || update_count !== 32'd12) begin
            failures++;
            $display("FAIL three_beats_counts: lc=%0d uc=%0d required 2/12", line_count, update_count);
        end
        cyc = 0;
        while (!done && cyc < 6) begin
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL three_beats_done: done=%b required 1", done);
        end
        step();
    endtask

    task automatic test_exact_eight();
        logic [511:0] exp_line;
        logic extra;
        int cyc;
        line_ready = 1'b1;
        beat(4'hF, 64'h21, 2'h2, 1'b0);
        step();
        beat(4'hF, 64'h25, 2'h0, 1'b1);
        step();
        idle_inputs();
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = 64'h21 + 64'(k);
        checks++;
        if (line_valid !== 1'b1 || line_data !== exp_line) begin
            failures++;
            $display("FAIL exact_eight_line: valid=%b data=%h required %h", line_valid, line_data, exp_line);
        end
        step();
        extra = 1'b0;
        cyc = 0;
        while (!done && cyc < 6) begin
            if (line_valid) extra = 1'b1;
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || extra !== 1'b0 || line_count !== 32'd1) begin
            failures++;
            $display("FAIL exact_eight_no_pad: done=%b extra_line=%b lc=%0d required 1/0/1", done, extra, line_count);
        end
        step();
    endtask

    task automatic test_overflow();
        int cyc;
        line_ready = 1'b0;
        for (int b = 0; b < 18; b++) begin
            beat(4'hF, 64'(4 * b + 1), (b == 0) ? 2'h2 : 2'h0, 1'b0);
            step();
            if (b == 9) begin
                checks++;
                if (almost_full !== 1'b0) begin
                    failures++;
                    $display("FAIL almost_full_at_5: got %b required 0", almost_full);
                end
            end
            if (b == 11) begin
                checks++;
                if (almost_full !== 1'b1) begin
                    failures++;
                    $display("FAIL almost_full_at_6: got %b required 1", almost_full);
                end
            end
            if (b == 15) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL overflow_at_8: got %b required 0", overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || line_count !== 32'd9) begin
            failures++;
            $display("FAIL overflow_at_9: ovf=%b lc=%0d required 1/9", overflow, line_count);
        end
        checks++;
        if (line_data[63:0] !== 64'h1) begin
            failures++;
            $display("FAIL overflow_head: slot0=%h required 1", line_data[63:0]);
        end
        idle_inputs();
        last_input_in = 1'b1;
        step();
        last_input_in = 1'b0;
        line_ready = 1'b1;
        cyc = 0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_drain: done=%b ovf=%b required 1/1", done, overflow);
        end
        step();
    endtask

    task automatic test_zero_updates();
        logic seen;
        int cyc;
        line_ready = 1'b1;
        beat(4'h0, 64'h77, 2'h2, 1'b1);
        step();
        idle_inputs();
        seen = 1'b0;
        cyc = 0;
        while (!done && cyc < 6) begin
            if (line_valid) seen = 1'b1;
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || cyc > 2 || seen !== 1'b0) begin
            failures++;
            $display("FAIL zero_updates_done: done=%b cycles=%0d line_seen=%b required 1/<=2/0", done, cyc, seen);
        end
        checks++;
        if (update_count !== 32'd0 || line_count !== 32'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL zero_updates_counts: uc=%0d lc=%0d ovf=%b required 0/0/0", update_count, line_count, overflow);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [511:0] exp_line;
        int cyc;
        line_ready = 1'b1;
        beat(4'hF, 64'h51, 2'h2, 1'b0);
        step();
        beat(4'b0001, 64'h55, 2'h0, 1'b0);
        step();
        checks++;
        if (update_count !== 32'd5) begin
            failures++;
            $display("FAIL reset_mid_setup: uc=%0d required 5", update_count);
        end
        idle_inputs();
        rst = 1'b1;
        step();
        checks++;
        if ({line_valid, almost_full, overflow, done} !== 4'b0 || line_data !== '0
            || update_count !== 32'd0 || line_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: valid=%b af=%b ovf=%b done=%b uc=%0d lc=%0d, all required 0",
                     line_valid, almost_full, overflow, done, update_count, line_count);
        end
        rst = 1'b0;
        step();
        beat(4'hF, 64'h100, 2'h2, 1'b0);
        step();
        beat(4'hF, 64'h104, 2'h0, 1'b0);
        step();
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = 64'h100 + 64'(k);
        checks++;
        if (line_valid !== 1'b1 || line_data !== exp_line || update_count !== 32'd8) begin
            failures++;
            $display("FAIL reset_mid_fresh_line: valid=%b uc=%0d data=%h required %h", line_valid, update_count, line_data, exp_line);
        end
        idle_inputs();
        last_input_in = 1'b1;
        step();
        last_input_in = 1'b0;
        cyc = 0;
        while (!done && cyc < 6) begin
            step();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || line_count !== 32'd1) begin
            failures++;
            $display("FAIL reset_mid_no_stale: done=%b lc=%0d required 1/1", done, line_count);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_padded_line();
        test_three_beats();
        test_exact_eight();
        test_overflow();
        test_zero_updates();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
